// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int LINE_W     = 128;
  localparam int WORD_OFF_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WB_REQ,
    S_RF_REQ,
    S_RF_WAIT,
    S_DONE
  } state_t;

  // Overlay the enabled bytes of a 32-bit word onto the selected word of a line.
  function automatic logic [LINE_W-1:0] merge_word(
    input logic [LINE_W-1:0]     line,
    input logic [31:0]           word,
    input logic [3:0]            mask,
    input logic [WORD_OFF_W-1:0] off
  );
    logic [LINE_W-1:0] result;
    int base;
    result = line;
    base   = int'(off) * 32;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) result[base + b*8 +: 8] = word[b*8 +: 8];
    end
    return result;
  endfunction

  // Pick one 32-bit word out of a line.
  function automatic logic [31:0] get_word(
    input logic [LINE_W-1:0]     line,
    input logic [WORD_OFF_W-1:0] off
  );
    return line[int'(off)*32 +: 32];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage: one write port, combinational read.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = 6,
  parameter int TAG_W     = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_dirty,
  input  logic [LINE_W-1:0] wr_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // Status bits are cleared on reset; any write installs a valid line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  // Tag and data need no reset because the valid bit guards them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped write-back write-allocate data cache between the core and line memory.
module dcache_dm_wb
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_din,
  input  logic [3:0]        cpu_we,
  input  logic              cpu_re,
  output logic [31:0]       cpu_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-5:0] mem_req_addr,
  output logic              mem_req_data_valid,
  input  logic              mem_req_data_ready,
  output logic [LINE_W-1:0] mem_req_data_bits,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  state_t state, next_state;

  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_din;
  logic [3:0]        req_we;
  logic              req_re;
  logic              cmd_done;
  logic              data_done;

  logic [ADDR_W-1:0]     lk_addr;
  logic [IDX_W-1:0]      lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [WORD_OFF_W-1:0] lk_off;

  logic              rd_valid;
  logic              rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;

  logic              arr_we;
  logic              arr_dirty;
  logic [LINE_W-1:0] arr_wdata;

  logic cpu_req;
  logic cpu_store;
  logic req_store;
  logic hit;
  logic accept_miss;
  logic load_hit;
  logic refill_load;

  // In IDLE the live core request indexes the array; afterwards only the latched copy does.
  assign lk_addr = (state == S_IDLE) ? cpu_addr : req_addr;
  assign lk_idx  = lk_addr[4 +: IDX_W];
  assign lk_tag  = lk_addr[ADDR_W-1 -: TAG_W];
  assign lk_off  = lk_addr[3:2];

  assign cpu_store = (cpu_we != 4'b0000);
  assign cpu_req   = cpu_store || cpu_re;
  assign req_store = (req_we != 4'b0000);
  assign hit       = rd_valid && (rd_tag == lk_tag);

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_index (lk_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_we),
    .wr_index (lk_idx),
    .wr_tag   (lk_tag),
    .wr_dirty (arr_dirty),
    .wr_data  (arr_wdata)
  );

  // The victim line is read straight from the array; it cannot change while a write-back is pending.
  assign mem_req_data_bits = rd_data;

  // Next-state, memory-side handshakes and array write control.
  always_comb begin
    next_state         = state;
    arr_we             = 1'b0;
    arr_dirty          = 1'b0;
    arr_wdata          = rd_data;
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_addr       = lk_addr[ADDR_W-1:4];
    mem_req_data_valid = 1'b0;
    accept_miss        = 1'b0;
    load_hit           = 1'b0;
    refill_load        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            if (cpu_store) begin
              arr_we    = 1'b1;
              arr_dirty = 1'b1;
              arr_wdata = merge_word(rd_data, cpu_din, cpu_we, lk_off);
            end else begin
              load_hit = 1'b1;
            end
          end else begin
            accept_miss = 1'b1;
            next_state  = S_MISS;
          end
        end
      end
      S_MISS: begin
        next_state = (rd_valid && rd_dirty) ? S_WB_REQ : S_RF_REQ;
      end
      S_WB_REQ: begin
        mem_req_valid      = !cmd_done;
        mem_req_rw         = 1'b1;
        mem_req_addr       = {rd_tag, lk_idx};
        mem_req_data_valid = !data_done;
        if ((cmd_done || mem_req_ready) && (data_done || mem_req_data_ready))
          next_state = S_RF_REQ;
      end
      S_RF_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) next_state = S_RF_WAIT;
      end
      S_RF_WAIT: begin
        if (mem_resp_valid) begin
          arr_we      = 1'b1;
          arr_dirty   = req_store;
          arr_wdata   = req_store ? merge_word(mem_resp_data, req_din, req_we, lk_off)
                                  : mem_resp_data;
          refill_load = req_re && !req_store;
          next_state  = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State, registered stall, load data, request latch and write-back handshake tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      stall     <= 1'b0;
      cpu_dout  <= '0;
      req_addr  <= '0;
      req_din   <= '0;
      req_we    <= '0;
      req_re    <= 1'b0;
      cmd_done  <= 1'b0;
      data_done <= 1'b0;
    end else begin
      state <= next_state;
      stall <= (next_state == S_MISS) || (next_state == S_WB_REQ) ||
               (next_state == S_RF_REQ) || (next_state == S_RF_WAIT);
      if (accept_miss) begin
        req_addr <= cpu_addr;
        req_din  <= cpu_din;
        req_we   <= cpu_we;
        req_re   <= cpu_re;
      end
      if (load_hit) cpu_dout <= get_word(rd_data, lk_off);
      if (refill_load) cpu_dout <= get_word(mem_resp_data, lk_off);
      if (state == S_MISS) begin
        cmd_done  <= 1'b0;
        data_done <= 1'b0;
      end else if (state == S_WB_REQ) begin
        if (mem_req_valid && mem_req_ready) cmd_done <= 1'b1;
        if (mem_req_data_valid && mem_req_data_ready) data_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Directed self-checking bench for the direct-mapped write-back data cache.
module tb_dcache_dm_wb;

  logic         clk;
  logic         reset;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_din;
  logic [3:0]   cpu_we;
  logic         cpu_re;
  logic [31:0]  cpu_dout;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  int checks;
  int failures;
  int rf_count;
  int wb_cmd_count;
  int wb_data_count;

  localparam logic [127:0] LINE_A   = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] LINE_A_M = 128'hDDDDDDDD_CCCCCCCC_BBBB5678_AAAAAAAA;
  localparam logic [127:0] LINE_B   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_B_M = 128'h44444444_33333333_22222222_CAFEF00D;
  localparam logic [127:0] LINE_C   = 128'h88888888_77777777_66666666_55555555;

  dcache_dm_wb dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_addr           (cpu_addr),
    .cpu_din            (cpu_din),
    .cpu_we             (cpu_we),
    .cpu_re             (cpu_re),
    .cpu_dout           (cpu_dout),
    .stall              (stall),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_rw         (mem_req_rw),
    .mem_req_addr       (mem_req_addr),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count completed memory handshakes per channel.
  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready && !mem_req_rw) rf_count++;
    if (mem_req_valid && mem_req_ready && mem_req_rw) wb_cmd_count++;
    if (mem_req_data_valid && mem_req_data_ready) wb_data_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic re,
                                input logic [3:0] we, input logic [31:0] din);
    cpu_addr = addr;
    cpu_re   = re;
    cpu_we   = we;
    cpu_din  = din;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rf_count = 0; wb_cmd_count = 0; wb_data_count = 0;
    reset = 1'b0;
    mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    apply_stimulus(32'h0, 1'b0, 4'b0000, 32'h0);

    // Reset state
    tick(); tick();
    check_output("rst_stall", stall, 0);
    check_output("rst_dout", cpu_dout, 0);
    check_output("rst_req_valid", mem_req_valid, 0);
    check_output("rst_data_valid", mem_req_data_valid, 0);
    check_output("rst_rw", mem_req_rw, 0);
    reset = 1'b1;

    // Cold load miss of 0x100
    apply_stimulus(32'h100, 1'b1, 4'b0000, 32'h0);
    tick();
    check_output("miss_stall", stall, 1);
    check_output("miss_no_req", mem_req_valid, 0);
    tick();
    check_output("rf1_valid", mem_req_valid, 1);
    check_output("rf1_rw", mem_req_rw, 0);
    check_output("rf1_addr", mem_req_addr, 28'h10);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check_output("rf1_wait_valid", mem_req_valid, 0);
    check_output("rf1_wait_stall", stall, 1);
    mem_resp_valid = 1'b1; mem_resp_data = LINE_A;
    tick();
    mem_resp_valid = 1'b0;
    check_output("done1_stall", stall, 0);
    check_output("done1_dout", cpu_dout, 32'hAAAAAAAA);
    tick();

    // Hit on word 1 of the same line
    apply_stimulus(32'h104, 1'b1, 4'b0000, 32'h0);
    tick();
    check_output("hit1_dout", cpu_dout, 32'hBBBBBBBB);
    check_output("hit1_stall", stall, 0);
    check_output("hit1_no_req", mem_req_valid, 0);

    // Partial store hit, then read back and a back-to-back hit
    apply_stimulus(32'h104, 1'b0, 4'b0011, 32'h12345678);
    tick();
    check_output("st_stall", stall, 0);
    check_output("st_no_req", mem_req_valid, 0);
    apply_stimulus(32'h104, 1'b1, 4'b0000, 32'h0);
    tick();
    check_output("st_readback", cpu_dout, 32'hBBBB5678);
    apply_stimulus(32'h108, 1'b1, 4'b0000, 32'h0);
    tick();
    check_output("b2b_hit", cpu_dout, 32'hCCCCCCCC);
    check_output("b2b_stall", stall, 0);

    // Conflict miss on 0x500 evicts the dirty line, data channel first
    apply_stimulus(32'h500, 1'b1, 4'b0000, 32'h0);
    tick();
    check_output("conf_stall", stall, 1);
    tick();
    check_output("wb1_valid", mem_req_valid, 1);
    check_output("wb1_rw", mem_req_rw, 1);
    check_output("wb1_addr", mem_req_addr, 28'h10);
    check_output("wb1_dvalid", mem_req_data_valid, 1);
    check_output("wb1_bits", mem_req_data_bits, LINE_A_M);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("wb1_hold_valid", mem_req_valid, 1);
      check_output("wb1_hold_addr", mem_req_addr, 28'h10);
      check_output("wb1_hold_bits", mem_req_data_bits, LINE_A_M);
    end
    mem_req_data_ready = 1'b1;
    tick();
    mem_req_data_ready = 1'b0;
    check_output("wb1_dvalid_drop", mem_req_data_valid, 0);
    check_output("wb1_cmd_still", mem_req_valid, 1);
    check_output("wb1_rw_still", mem_req_rw, 1);
    mem_req_ready = 1'b1;
    tick();
    check_output("rf2_valid", mem_req_valid, 1);
    check_output("rf2_rw", mem_req_rw, 0);
    check_output("rf2_addr", mem_req_addr, 28'h50);
    tick();
    mem_req_ready = 1'b0;
    check_output("rf2_wait_valid", mem_req_valid, 0);
    mem_resp_valid = 1'b1; mem_resp_data = LINE_B;
    tick();
    mem_resp_valid = 1'b0;
    check_output("done2_dout", cpu_dout, 32'h11111111);
    check_output("done2_stall", stall, 0);
    check_output("cnt_wb_cmd1", wb_cmd_count, 1);
    check_output("cnt_wb_data1", wb_data_count, 1);
    check_output("cnt_rf2", rf_count, 2);
    tick();

    // Dirty the new line, then evict it with the command channel first
    apply_stimulus(32'h500, 1'b0, 4'b1111, 32'hCAFEF00D);
    tick();
    apply_stimulus(32'h900, 1'b1, 4'b0000, 32'h0);
    tick();
    check_output("conf2_stall", stall, 1);
    tick();
    check_output("wb2_addr", mem_req_addr, 28'h50);
    check_output("wb2_bits", mem_req_data_bits, LINE_B_M);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check_output("wb2_cmd_drop", mem_req_valid, 0);
    check_output("wb2_dvalid_still", mem_req_data_valid, 1);
    mem_req_data_ready = 1'b1;
    tick();
    mem_req_data_ready = 1'b0;
    check_output("rf3_valid", mem_req_valid, 1);
    check_output("rf3_rw", mem_req_rw, 0);
    check_output("rf3_addr", mem_req_addr, 28'h90);
    check_output("cnt_wb_cmd2", wb_cmd_count, 2);
    check_output("cnt_wb_data2", wb_data_count, 2);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check_output("rf3_wait_stall", stall, 1);

    // Reset while waiting for the refill
    reset = 1'b0;
    apply_stimulus(32'h0, 1'b0, 4'b0000, 32'h0);
    tick();
    reset = 1'b1;
    check_output("midrst_stall", stall, 0);
    check_output("midrst_valid", mem_req_valid, 0);
    check_output("midrst_dout", cpu_dout, 0);

    // Line 0x10 was valid before reset; it must miss now
    apply_stimulus(32'h104, 1'b1, 4'b0000, 32'h0);
    tick();
    check_output("post_rst_miss", stall, 1);
    tick();
    check_output("rf4_valid", mem_req_valid, 1);
    check_output("rf4_rw", mem_req_rw, 0);
    check_output("rf4_addr", mem_req_addr, 28'h10);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = LINE_C;
    tick();
    mem_resp_valid = 1'b0;
    check_output("done4_dout", cpu_dout, 32'h66666666);
    check_output("done4_stall", stall, 0);
    check_output("cnt_rf4", rf_count, 4);
    check_output("cnt_wb_cmd_final", wb_cmd_count, 2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
